yd_dbus_lsu: RTL and testbench
==============================

YD_DBUS_LSU -- requirements
Module: yd_dbus_lsu

Interface
REQ-001 SHALL have parameter DW, default 16, data width.
REQ-002 SHALL have parameter AW, default 16, address width.
REQ-003 SHALL have parameter WB_DEPTH, default 4, write-buffer entries; power of 2, range 2..16.
REQ-004 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports chN_req  in  1  access request, N=0 (older issue slot), N=1 (younger slot).
REQ-007 SHALL have ports chN_we  in  1  1=store, 0=load.
REQ-008 SHALL have ports chN_addr  in  AW, and chN_wdata  in  DW.
REQ-009 SHALL have ports chN_gnt  out  1  request accepted this cycle (combinational).
REQ-010 SHALL have ports chN_rvalid  out  1, and chN_rdata  out  DW, load data return.
REQ-011 SHALL have ports m_req  out  1; m_we  out  1; m_addr  out  AW; m_din  out  DW; m_ready  in  1; m_dout  in  DW.
REQ-012 SHALL have port stall  out  1  high when any chN_req is high and its chN_gnt is low.
REQ-013 SHALL have port wb_count  out  $clog2(WB_DEPTH)+1  buffered store count.

Function
REQ-014 SHALL post stores into a FIFO write buffer; a store is granted when a free entry exists, with free space taken from the count at cycle start, so a same-cycle pop gives no credit.
REQ-015 SHALL accept two stores in one cycle only if 2 entries are free, pushing ch0 before ch1; with 1 entry free, SHALL grant ch0 only.
REQ-016 SHALL grant in program order: ch1_gnt SHALL be 0 whenever ch0_req=1 and ch0_gnt=0.
REQ-017 SHALL issue at most one memory transfer per cycle; a transfer is accepted when m_req=1 and m_ready=1.
REQ-018 SHALL grant a load only if m_ready=1, its address hits no valid buffer entry, and it hits no store pushed by ch0 in the same cycle.
REQ-019 SHALL grant a ch1 load only if ch0 is not a granted load in the same cycle.
REQ-020 SHALL, on an address hit, hold the load ungranted until the buffer drains past every matching entry.
REQ-021 SHALL select the memory port by this priority: (a) head-of-buffer write when wb_count==WB_DEPTH; (b) a grantable load, ch0 before ch1; (c) head-of-buffer write when wb_count>0; (d) idle, with m_req=0.
REQ-022 SHALL pop the head entry only on an accepted write.
REQ-023 SHALL return load data one cycle after acceptance: chN_rvalid=1 for exactly one cycle and chN_rdata=m_dout; chN_rdata SHALL be 0 when chN_rvalid=0.
REQ-024 SHALL, when m_req=0, drive m_we=0, m_addr=0 and m_din=0.
REQ-025 SHALL wrap the buffer pointers modulo WB_DEPTH, and wb_count SHALL never exceed WB_DEPTH or go below 0.
REQ-026 SHALL keep chN_gnt=0 when chN_req=0.

Reset
REQ-027 SHALL, while rst=1, drive all outputs to 0, flush the buffer (wb_count=0), reset both pointers to 0, and drop any pending read return.
REQ-028 SHALL, for a load accepted in the cycle rst rises, assert no rvalid afterwards.
REQ-029 SHALL grant no request while rst=1.

Verification
REQ-030 SHALL cover: WB_DEPTH=4, m_ready=0, ch0 stores to 0x10..0x13 over 4 cycles, then a 5th store -> first 4 granted, wb_count=4, 5th ungranted, stall=1.
REQ-031 SHALL cover: ch0 store [0x20]=0xAAAA and ch1 load 0x20 in the same cycle, m_ready=1 -> ch0_gnt=1, ch1_gnt=0; ch1 granted only after the write to 0x20 is accepted; ch1_rdata=0xAAAA.
REQ-032 SHALL cover: both channels load 0x30 and 0x31, m_ready=1 -> ch0 granted in cycle T and ch1 in T+1; rvalid at T+1 and T+2.
REQ-033 SHALL cover: buffer holds 2 stores, ch0 loads 0x40 (no hit), m_ready=1 -> the load goes first, then the writes drain in FIFO order.
REQ-034 SHALL cover: buffer full, ch0 load with no hit -> the head write is issued first and the load is granted in the following cycle.
REQ-035 SHALL cover: rst asserted for 1 cycle with 3 entries buffered and a read outstanding -> wb_count=0 next cycle, no rvalid, m_req=0.

Source files
------------

// File: rtl/yd_dbus_lsu.sv
// Dual-issue load/store unit: stores post into a FIFO write buffer, loads go straight to the single memory port.
// Grants are combinational; load data returns one cycle after acceptance. Loads that alias a buffered store wait for the drain.
module yd_dbus_lsu #(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int WB_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ch0_req,
    input  logic                        ch0_we,
    input  logic [AW-1:0]               ch0_addr,
    input  logic [DW-1:0]               ch0_wdata,
    output logic                        ch0_gnt,
    output logic                        ch0_rvalid,
    output logic [DW-1:0]               ch0_rdata,
    input  logic                        ch1_req,
    input  logic                        ch1_we,
    input  logic [AW-1:0]               ch1_addr,
    input  logic [DW-1:0]               ch1_wdata,
    output logic                        ch1_gnt,
    output logic                        ch1_rvalid,
    output logic [DW-1:0]               ch1_rdata,
    output logic                        m_req,
    output logic                        m_we,
    output logic [AW-1:0]               m_addr,
    output logic [DW-1:0]               m_din,
    input  logic                        m_ready,
    input  logic [DW-1:0]               m_dout,
    output logic                        stall,
    output logic [$clog2(WB_DEPTH):0]   wb_count
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] wb_addr [WB_DEPTH];
    logic [DW-1:0] wb_data [WB_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_idx1;
    logic [CW-1:0] count;
    logic [CW-1:0] free_cnt;
    logic [1:0]    rd_pend;

    logic          full;
    logic          hit0;
    logic          hit1;
    logic [PW-1:0] off;
    logic          st0;
    logic          ld0;
    logic          st1;
    logic          ld1;
    logic          blk0;
    logic          push0;
    logic          push1;
    logic          pop;

    assign full     = (count == CW'(WB_DEPTH));
    assign free_cnt = CW'(WB_DEPTH) - count;

    // Compare each request address against every live buffer slot.
    always_comb begin
        hit0 = 1'b0;
        hit1 = 1'b0;
        off  = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ({1'b0, off} < count) begin
                if (wb_addr[i] == ch0_addr) hit0 = 1'b1;
                if (wb_addr[i] == ch1_addr) hit1 = 1'b1;
            end
        end
    end

    // Free space is taken from the start-of-cycle count, so a same-cycle pop gives no credit.
    assign st0     = ch0_req & ch0_we & (free_cnt != '0);
    assign ld0     = ch0_req & ~ch0_we & m_ready & ~full & ~hit0;
    assign ch0_gnt = ~rst & (st0 | ld0);
    assign blk0    = ch0_req & ~ch0_gnt;
    assign push0   = ch0_gnt & ch0_we;

    assign st1 = ch1_req & ch1_we & ~blk0 &
                 (push0 ? (free_cnt >= CW'(2)) : (free_cnt != '0));
    assign ld1 = ch1_req & ~ch1_we & ~blk0 & ~(ch0_req & ~ch0_we) &
                 m_ready & ~full & ~hit1 & ~(push0 & (ch0_addr == ch1_addr));
    assign ch1_gnt = ~rst & (st1 | ld1);
    assign push1   = ch1_gnt & ch1_we;

    assign stall = ~rst & (blk0 | (ch1_req & ~ch1_gnt));

    // Memory port arbitration: full-buffer drain, then loads, then opportunistic drain.
    always_comb begin
        m_req  = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_din  = '0;
        if (!rst) begin
            if (full) begin
                m_req  = 1'b1;
                m_we   = 1'b1;
                m_addr = wb_addr[rd_ptr];
                m_din  = wb_data[rd_ptr];
            end else if (ld0) begin
                m_req  = 1'b1;
                m_addr = ch0_addr;
            end else if (ld1) begin
                m_req  = 1'b1;
                m_addr = ch1_addr;
            end else if (count != '0) begin
                m_req  = 1'b1;
                m_we   = 1'b1;
                m_addr = wb_addr[rd_ptr];
                m_din  = wb_data[rd_ptr];
            end
        end
    end

    assign pop     = m_req & m_we & m_ready;
    assign wr_idx1 = push0 ? (wr_ptr + PW'(1)) : wr_ptr;

    always_ff @(posedge clk) begin
        if (push0) begin
            wb_addr[wr_ptr] <= ch0_addr;
            wb_data[wr_ptr] <= ch0_wdata;
        end
        if (push1) begin
            wb_addr[wr_idx1] <= ch1_addr;
            wb_data[wr_idx1] <= ch1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            rd_pend <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(push0) + PW'(push1);
            rd_ptr  <= rd_ptr + PW'(pop);
            count   <= count + CW'(push0) + CW'(push1) - CW'(pop);
            rd_pend <= {ch1_gnt & ~ch1_we, ch0_gnt & ~ch0_we};
        end
    end

    assign ch0_rvalid = rd_pend[0] & ~rst;
    assign ch1_rvalid = rd_pend[1] & ~rst;
    assign ch0_rdata  = ch0_rvalid ? m_dout : '0;
    assign ch1_rdata  = ch1_rvalid ? m_dout : '0;
    assign wb_count   = rst ? '0 : count;

endmodule

// File: tb/tb_yd_dbus_lsu.sv
// Directed bench for yd_dbus_lsu with a behavioural memory behind the port.
module tb_yd_dbus_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [15:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
    logic        c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
    logic [15:0] c0_rdata, c1_rdata;
    logic        m_req, m_we, m_ready;
    logic [15:0] m_addr, m_din;
    logic [15:0] m_dout = 16'h0;
    logic        stall;
    logic [2:0]  wb_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [int];

    always #5 clk = ~clk;

    yd_dbus_lsu #(.DW(16), .AW(16), .WB_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .ch0_req(c0_req), .ch0_we(c0_we), .ch0_addr(c0_addr), .ch0_wdata(c0_wdata),
        .ch0_gnt(c0_gnt), .ch0_rvalid(c0_rvalid), .ch0_rdata(c0_rdata),
        .ch1_req(c1_req), .ch1_we(c1_we), .ch1_addr(c1_addr), .ch1_wdata(c1_wdata),
        .ch1_gnt(c1_gnt), .ch1_rvalid(c1_rvalid), .ch1_rdata(c1_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_din(m_din),
        .m_ready(m_ready), .m_dout(m_dout),
        .stall(stall), .wb_count(wb_count)
    );

    // Unwritten locations read back as 0xC000 ^ addr.
    always @(posedge clk) begin
        if (m_req && m_ready) begin
            if (m_we) mem[int'(m_addr)] = m_din;
            else m_dout <= mem.exists(int'(m_addr)) ? mem[int'(m_addr)] : (16'hC000 ^ m_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic we, input logic [15:0] addr);
        c0_req = req; c0_we = we; c0_addr = addr; c0_wdata = 16'hD000 | addr;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [15:0] addr);
        c1_req = req; c1_we = we; c1_addr = addr; c1_wdata = 16'hD000 | addr;
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b1;
        drv0(1'b1, 1'b0, 16'h0005);
        drv1(1'b1, 1'b1, 16'h0006);
        tick(); tick(); #2;
        chk("rst_gnt0", c0_gnt, 0);
        chk("rst_gnt1", c1_gnt, 0);
        chk("rst_stall", stall, 0);
        chk("rst_mreq", m_req, 0);
        chk("rst_count", wb_count, 0);
        chk("rst_rvalid", c0_rvalid, 0);

        // Fill the buffer with the memory stalled.
        tick(); rst = 1'b0; m_ready = 1'b0; drv0(1'b0, 1'b0, 0); drv1(1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); drv0(1'b1, 1'b1, 16'h0010 + 16'(i)); #2;
            chk("fill_gnt", c0_gnt, 1);
            if (i == 1) begin
                chk("fill_mreq", m_req, 1);
                chk("fill_maddr", m_addr, 16'h0010);
            end
        end
        tick(); drv0(1'b1, 1'b1, 16'h0014); #2;
        chk("full_count", wb_count, 4);
        chk("full_gnt", c0_gnt, 0);
        chk("full_stall", stall, 1);
        for (int i = 0; i < 4; i++) begin
            tick(); drv0(1'b0, 1'b0, 0); m_ready = 1'b1; #2;
            chk("drain_we", m_we, 1);
            chk("drain_addr", m_addr, 16'h0010 + 16'(i));
            chk("drain_din", m_din, 16'hD010 + 16'(i));
        end
        tick(); #2;
        chk("drain_count", wb_count, 0);
        chk("drain_idle", m_req, 0);

        // Store then aliasing load in the same cycle.
        tick(); drv0(1'b1, 1'b1, 16'h0020); c0_wdata = 16'hAAAA; drv1(1'b1, 1'b0, 16'h0020); #2;
        chk("alias_gnt0", c0_gnt, 1);
        chk("alias_gnt1", c1_gnt, 0);
        chk("alias_idle", m_req, 0);
        tick(); drv0(1'b0, 1'b0, 0); #2;
        chk("alias_hold", c1_gnt, 0);
        chk("alias_wr", {m_req, m_we, m_addr, m_din}, {2'b11, 16'h0020, 16'hAAAA});
        tick(); #2;
        chk("alias_gnt", c1_gnt, 1);
        chk("alias_rd", {m_req, m_we, m_addr}, {2'b10, 16'h0020});
        tick(); drv1(1'b0, 1'b0, 0); #2;
        chk("alias_rv", {c0_rvalid, c1_rvalid, c1_rdata}, {2'b01, 16'hAAAA});
        tick(); #2;
        chk("alias_rv_off", {c1_rvalid, c1_rdata}, 0);

        // Two loads in one cycle serialise.
        tick(); drv0(1'b1, 1'b0, 16'h0030); drv1(1'b1, 1'b0, 16'h0031); #2;
        chk("ll_gnt", {c0_gnt, c1_gnt}, 2'b10);
        chk("ll_addr0", m_addr, 16'h0030);
        tick(); drv0(1'b0, 1'b0, 0); #2;
        chk("ll_gnt1", c1_gnt, 1);
        chk("ll_addr1", m_addr, 16'h0031);
        chk("ll_rv0", {c0_rvalid, c0_rdata}, {1'b1, 16'hC030});
        tick(); drv1(1'b0, 1'b0, 0); #2;
        chk("ll_rv1", {c0_rvalid, c1_rvalid, c1_rdata}, {2'b01, 16'hC031});

        // Non-aliasing load bypasses two buffered stores.
        tick(); m_ready = 1'b0; drv0(1'b1, 1'b1, 16'h0050); drv1(1'b1, 1'b1, 16'h0051); #2;
        chk("ss_gnt", {c0_gnt, c1_gnt}, 2'b11);
        tick(); drv0(1'b0, 1'b0, 0); drv1(1'b0, 1'b0, 0); #2;
        chk("ss_count", wb_count, 2);
        tick(); drv0(1'b1, 1'b0, 16'h0040); m_ready = 1'b1; #2;
        chk("byp_gnt", c0_gnt, 1);
        chk("byp_rd", {m_req, m_we, m_addr}, {2'b10, 16'h0040});
        tick(); drv0(1'b0, 1'b0, 0); #2;
        chk("byp_rv", {c0_rvalid, c0_rdata}, {1'b1, 16'hC040});
        chk("byp_wr0", {m_we, m_addr, m_din}, {1'b1, 16'h0050, 16'hD050});
        tick(); #2;
        chk("byp_wr1", {m_we, m_addr, m_din}, {1'b1, 16'h0051, 16'hD051});
        tick(); #2;
        chk("byp_count", wb_count, 0);

        // One free entry: only ch0's store fits.
        tick(); m_ready = 1'b0; drv0(1'b1, 1'b1, 16'h0060); drv1(1'b1, 1'b1, 16'h0061); #2;
        tick(); drv0(1'b1, 1'b1, 16'h0062); drv1(1'b0, 1'b0, 0); #2;
        tick(); drv0(1'b1, 1'b1, 16'h0063); drv1(1'b1, 1'b1, 16'h0064); #2;
        chk("one_free_gnt", {c0_gnt, c1_gnt, stall}, 3'b101);
        // Full buffer: head write first, load next cycle.
        tick(); drv0(1'b1, 1'b0, 16'h0070); drv1(1'b0, 1'b0, 0); m_ready = 1'b1; #2;
        chk("fullld_count", wb_count, 4);
        chk("fullld_gnt", c0_gnt, 0);
        chk("fullld_wr", {m_we, m_addr}, {1'b1, 16'h0060});
        tick(); #2;
        chk("fullld_gnt2", c0_gnt, 1);
        chk("fullld_rd", {m_we, m_addr}, {1'b0, 16'h0070});
        // Load aliasing 0x62 waits until that entry has drained.
        tick(); drv0(1'b1, 1'b0, 16'h0062); #2;
        chk("hold_rv", {c0_rvalid, c0_rdata}, {1'b1, 16'hC070});
        chk("hold_gnt_a", c0_gnt, 0);
        chk("hold_wr_a", m_addr, 16'h0061);
        tick(); #2;
        chk("hold_gnt_b", c0_gnt, 0);
        chk("hold_wr_b", {m_we, m_addr}, {1'b1, 16'h0062});
        tick(); #2;
        chk("hold_gnt_c", c0_gnt, 1);
        chk("hold_rd", {m_we, m_addr}, {1'b0, 16'h0062});
        tick(); drv0(1'b0, 1'b0, 0); #2;
        chk("hold_data", {c0_rvalid, c0_rdata}, {1'b1, 16'hD062});
        chk("hold_last_wr", {m_we, m_addr}, {1'b1, 16'h0063});
        tick(); #2;
        chk("hold_empty", wb_count, 0);

        // Reset with three stores buffered and a read return pending.
        tick(); m_ready = 1'b0; drv0(1'b1, 1'b1, 16'h0080); drv1(1'b1, 1'b1, 16'h0081); #2;
        tick(); drv0(1'b1, 1'b1, 16'h0082); drv1(1'b0, 1'b0, 0); #2;
        tick(); drv0(1'b1, 1'b0, 16'h0090); m_ready = 1'b1; #2;
        chk("pre_rst_count", wb_count, 3);
        chk("pre_rst_gnt", c0_gnt, 1);
        tick(); rst = 1'b1; drv0(1'b1, 1'b0, 16'h0091); #2;
        chk("in_rst_out", {c0_gnt, c0_rvalid, c0_rdata, m_req, stall, wb_count},
            {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0});
        tick(); rst = 1'b0; drv0(1'b0, 1'b0, 0); #2;
        chk("post_rst", {wb_count, c0_rvalid, c1_rvalid, m_req}, {3'd0, 3'b000});
        tick(); #2;
        chk("post_rst2", {wb_count, c0_rvalid, m_req}, {3'd0, 2'b00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
